// File: rtl/iq_pht_pkg.sv
// Shared PHT geometry and the saturating-counter rule used by the table and its update path.
package iq_pht_pkg;

    localparam int PHT_IDX_WIDTH = 11;
    localparam int PHT_CTR_WIDTH = 2;

    // Saturating step: never wraps past all-ones when taken or past zero when not taken.
    function automatic logic [PHT_CTR_WIDTH-1:0] pht_ctr_next(
        input logic [PHT_CTR_WIDTH-1:0] old,
        input logic                     taken
    );
        logic [PHT_CTR_WIDTH-1:0] nxt;
        nxt = old;
        if (taken) begin
            if (old != {PHT_CTR_WIDTH{1'b1}}) nxt = old + 1'b1;
        end else begin
            if (old != {PHT_CTR_WIDTH{1'b0}}) nxt = old - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Two-push / one-pop in-order buffer of {idx, taken}; slot 0 is written ahead of slot 1.
module pht_upd_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_0,
    input  logic [W-1:0]  din_0,
    input  logic          push_1,
    input  logic [W-1:0]  din_1,
    input  logic          pop,
    output logic [AW:0]   count,
    output logic [W-1:0]  head,
    output logic          not_empty
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  wptr_p1;
    logic [AW:0]  n_push;
    logic [W-1:0] first_din;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wptr - rptr;
    assign not_empty = (wptr != rptr);
    assign head      = mem[rptr[AW-1:0]];

    assign wptr_p1   = wptr + (AW+1)'(1);
    assign n_push    = (AW+1)'(push_0) + (AW+1)'(push_1);
    assign first_din = push_0 ? din_0 : din_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + n_push;
            rptr <= rptr + (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_0 | push_1) mem[wptr[AW-1:0]] <= first_din;
        if (push_0 & push_1) mem[wptr_p1[AW-1:0]] <= din_1;
    end

endmodule

// File: rtl/pht_update_module.sv
// PHT write-side updater: buffers committed branch outcomes and applies saturating
// read-modify-writes through one read port and one write port, forwarding back-to-back hits.
module pht_update_module
    import iq_pht_pkg::*;
#(
    parameter int IDX_WIDTH  = PHT_IDX_WIDTH,
    parameter int CTR_WIDTH  = PHT_CTR_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_upd_vld_0,
    input  logic [IDX_WIDTH-1:0] i_upd_idx_0,
    input  logic                 i_upd_taken_0,
    input  logic                 i_upd_vld_1,
    input  logic [IDX_WIDTH-1:0] i_upd_idx_1,
    input  logic                 i_upd_taken_1,
    output logic                 o_upd_rdy,
    output logic [IDX_WIDTH-1:0] o_pht_ridx,
    input  logic [CTR_WIDTH-1:0] i_pht_rd_entry,
    output logic                 o_pht_wren,
    output logic [IDX_WIDTH-1:0] o_pht_widx,
    output logic [CTR_WIDTH-1:0] o_pht_wr_entry,
    output logic                 o_idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = IDX_WIDTH + 1;
    localparam logic [AW:0] RDY_LIMIT = (AW+1)'(FIFO_DEPTH - 2);

    logic [AW:0]          count;
    logic [EW-1:0]        head;
    logic                 not_empty;
    logic                 push_0;
    logic                 push_1;
    logic                 pop;
    logic [IDX_WIDTH-1:0] head_idx;
    logic                 head_taken;
    logic                 forward_hit;
    logic [CTR_WIDTH-1:0] ctr_old;
    logic [CTR_WIDTH-1:0] ctr_new;
    logic                 s1_vld;
    logic [IDX_WIDTH-1:0] s1_idx;
    logic [CTR_WIDTH-1:0] s1_ctr;

    // Handshake: a slot transfers on the cycle its vld is high while o_upd_rdy is high;
    // o_upd_rdy grants both slots together and depends on occupancy only, never on vld.
    assign o_upd_rdy = (count <= RDY_LIMIT);
    assign push_0    = i_upd_vld_0 & o_upd_rdy;
    assign push_1    = i_upd_vld_1 & o_upd_rdy;
    assign pop       = not_empty;

    pht_upd_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_0    (push_0),
        .din_0     ({i_upd_idx_0, i_upd_taken_0}),
        .push_1    (push_1),
        .din_1     ({i_upd_idx_1, i_upd_taken_1}),
        .pop       (pop),
        .count     (count),
        .head      (head),
        .not_empty (not_empty)
    );

    assign head_idx   = head[EW-1:1];
    assign head_taken = head[0];
    assign o_pht_ridx = head_idx;

    // The array has not yet absorbed the write in flight, so take it from stage 1 instead.
    assign forward_hit = s1_vld & (s1_idx == head_idx);
    assign ctr_old     = forward_hit ? s1_ctr : i_pht_rd_entry;

    generate
        if (CTR_WIDTH == PHT_CTR_WIDTH) begin : g_pkg_rule
            assign ctr_new = pht_ctr_next(ctr_old, head_taken);
        end else begin : g_wide_rule
            always_comb begin
                ctr_new = ctr_old;
                if (head_taken) begin
                    if (ctr_old != {CTR_WIDTH{1'b1}}) ctr_new = ctr_old + 1'b1;
                end else begin
                    if (ctr_old != {CTR_WIDTH{1'b0}}) ctr_new = ctr_old - 1'b1;
                end
            end
        end
    endgenerate

    // Saturated updates leave the PHT unchanged, so they retire without a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_idx <= '0;
            s1_ctr <= '0;
        end else begin
            s1_vld <= pop & (ctr_new != ctr_old);
            if (pop) begin
                s1_idx <= head_idx;
                s1_ctr <= ctr_new;
            end
        end
    end

    assign o_pht_wren     = s1_vld;
    assign o_pht_widx     = s1_idx;
    assign o_pht_wr_entry = s1_ctr;
    assign o_idle         = ~not_empty & ~s1_vld;

endmodule

// File: tb/tb_pht_update_module.sv
// Directed bench for pht_update_module: a bench-side PHT array, an in-order reference
// model of counter updates, and a write-stream scoreboard.
module tb_pht_update_module;

    localparam int IW  = 11;
    localparam int CW  = 2;
    localparam int D   = 8;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_upd_vld_0, i_upd_vld_1;
    logic [IW-1:0] i_upd_idx_0, i_upd_idx_1;
    logic          i_upd_taken_0, i_upd_taken_1;
    logic          o_upd_rdy;
    logic [IW-1:0] o_pht_ridx;
    logic [CW-1:0] i_pht_rd_entry;
    logic          o_pht_wren;
    logic [IW-1:0] o_pht_widx;
    logic [CW-1:0] o_pht_wr_entry;
    logic          o_idle;

    logic [CW-1:0]    pht     [1 << IW];
    logic [CW-1:0]    ref_pht [1 << IW];
    logic [IW+CW-1:0] exp_q[$];
    int               occ;
    int               errors = 0;
    int               checks = 0;

    pht_update_module #(
        .IDX_WIDTH  (IW),
        .CTR_WIDTH  (CW),
        .FIFO_DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_upd_vld_0    (i_upd_vld_0),
        .i_upd_idx_0    (i_upd_idx_0),
        .i_upd_taken_0  (i_upd_taken_0),
        .i_upd_vld_1    (i_upd_vld_1),
        .i_upd_idx_1    (i_upd_idx_1),
        .i_upd_taken_1  (i_upd_taken_1),
        .o_upd_rdy      (o_upd_rdy),
        .o_pht_ridx     (o_pht_ridx),
        .i_pht_rd_entry (i_pht_rd_entry),
        .o_pht_wren     (o_pht_wren),
        .o_pht_widx     (o_pht_widx),
        .o_pht_wr_entry (o_pht_wr_entry),
        .o_idle         (o_idle)
    );

    // Clock and the PHT array the DUT reads and writes.
    always #5 clk = ~clk;
    assign i_pht_rd_entry = pht[o_pht_ridx];
    always @(posedge clk) if (o_pht_wren) pht[o_pht_widx] <= o_pht_wr_entry;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pht_set(input int idx, input int val);
        pht[idx]     = CW'(val);
        ref_pht[idx] = CW'(val);
    endtask

    // Reference: updates apply to the table strictly in acceptance order.
    task automatic model_push(input logic [IW-1:0] idx, input logic taken);
        int o, n;
        o = ref_pht[idx];
        n = taken ? ((o < MAX) ? o + 1 : MAX) : ((o > 0) ? o - 1 : 0);
        if (n != o) exp_q.push_back({idx, CW'(n)});
        ref_pht[idx] = CW'(n);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic v0, input int x0, input logic t0,
                        input logic v1, input int x1, input logic t1);
        logic rdy_exp;
        int   pops;
        i_upd_vld_0 = v0; i_upd_idx_0 = IW'(x0); i_upd_taken_0 = t0;
        i_upd_vld_1 = v1; i_upd_idx_1 = IW'(x1); i_upd_taken_1 = t1;
        rdy_exp = (occ <= D - 2);
        chk("upd_rdy", int'(o_upd_rdy), int'(rdy_exp));
        pops = (occ > 0) ? 1 : 0;
        occ  = occ - pops;
        if (v0 && rdy_exp) begin model_push(IW'(x0), t0); occ++; end
        if (v1 && rdy_exp) begin model_push(IW'(x1), t1); occ++; end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Scoreboard: every PHT write must be the next expected one, in order.
    always @(negedge clk) begin
        if (!rst && o_pht_wren) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_stream: unexpected write idx=%0h val=%0h", o_pht_widx, o_pht_wr_entry);
            end else begin
                logic [IW+CW-1:0] e;
                e = exp_q.pop_front();
                if ({o_pht_widx, o_pht_wr_entry} !== e) begin
                    errors++;
                    $display("FAIL write_stream: got idx=%0h val=%0h expected idx=%0h val=%0h",
                             o_pht_widx, o_pht_wr_entry, e[IW+CW-1:CW], e[CW-1:0]);
                end
            end
        end
    end

    initial begin
        int wcnt;
        for (int i = 0; i < (1 << IW); i++) begin pht[i] = '0; ref_pht[i] = '0; end
        occ = 0;
        rst = 1'b1;
        i_upd_vld_0 = 0; i_upd_idx_0 = '0; i_upd_taken_0 = 0;
        i_upd_vld_1 = 0; i_upd_idx_1 = '0; i_upd_taken_1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_wren", int'(o_pht_wren), 0);
        chk("rst_widx", int'(o_pht_widx), 0);
        chk("rst_wr_entry", int'(o_pht_wr_entry), 0);
        chk("rst_rdy", int'(o_upd_rdy), 1);
        chk("rst_idle", int'(o_idle), 1);
        rst = 1'b0;

        // Single update: 1 -> 2 written two cycles after acceptance.
        pht_set('h155, 1);
        step(1, 'h155, 1, 0, 0, 0);
        chk("single_ridx", int'(o_pht_ridx), 'h155);
        chk("single_wren_n1", int'(o_pht_wren), 0);
        chk("single_idle_n1", int'(o_idle), 0);
        idle_steps(1);
        chk("single_wren_n2", int'(o_pht_wren), 1);
        chk("single_widx", int'(o_pht_widx), 'h155);
        chk("single_entry", int'(o_pht_wr_entry), 2);
        idle_steps(1);
        chk("single_idle_n3", int'(o_idle), 1);

        // Saturation at both ends: no write at all.
        pht_set('h7FF, 3);
        pht_set('h222, 0);
        step(1, 'h7FF, 1, 1, 'h222, 0);
        wcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_pht_wren) wcnt++;
            idle_steps(1);
        end
        chk("sat_writes", wcnt, 0);
        chk("sat_idle", int'(o_idle), 1);

        // Forwarding: same index twice in one cycle, 0 -> 1 -> 2.
        pht_set('h010, 0);
        step(1, 'h010, 1, 1, 'h010, 1);
        chk("fwd_wren_n1", int'(o_pht_wren), 0);
        idle_steps(1);
        chk("fwd_first_wren", int'(o_pht_wren), 1);
        chk("fwd_first_entry", int'(o_pht_wr_entry), 1);
        idle_steps(1);
        chk("fwd_second_wren", int'(o_pht_wren), 1);
        chk("fwd_second_entry", int'(o_pht_wr_entry), 2);
        idle_steps(2);

        // Slot 1 alone: 2 -> 1.
        pht_set('h3A0, 2);
        step(0, 0, 0, 1, 'h3A0, 0);
        chk("s1only_ridx", int'(o_pht_ridx), 'h3A0);
        idle_steps(1);
        chk("s1only_wren", int'(o_pht_wren), 1);
        chk("s1only_widx", int'(o_pht_widx), 'h3A0);
        chk("s1only_entry", int'(o_pht_wr_entry), 1);
        idle_steps(2);

        // Backpressure: two pushes every cycle until ready drops at 7 occupied.
        for (int k = 0; k < 32; k++) pht_set('h100 + k, k % 4);
        for (int s = 0; s < 10; s++) begin
            step(1, 'h100 + 2*s, s[0], 1, 'h101 + 2*s, ~s[0]);
            if (s == 5) begin
                chk("bp_occ_model", occ, 7);
                chk("bp_rdy_low", int'(o_upd_rdy), 0);
            end
        end
        idle_steps(12);
        chk("bp_drained_q", exp_q.size(), 0);
        chk("bp_idle", int'(o_idle), 1);

        // Reset with five entries buffered: everything pending is dropped.
        for (int k = 0; k < 16; k++) pht_set('h200 + k, 1);
        for (int s = 0; s < 4; s++) step(1, 'h200 + 2*s, 1, 1, 'h201 + 2*s, 0);
        chk("rst_occ_model", occ, 5);
        rst = 1'b1;
        #1;
        chk("midrst_wren", int'(o_pht_wren), 0);
        chk("midrst_rdy", int'(o_upd_rdy), 1);
        chk("midrst_idle", int'(o_idle), 1);
        exp_q.delete();
        occ = 0;
        i_upd_vld_0 = 0; i_upd_vld_1 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_pht_wren) wcnt++;
            idle_steps(1);
        end
        chk("postrst_writes", wcnt, 0);

        // Normal operation resumes after reset.
        pht_set('h050, 2);
        pht_set('h051, 2);
        step(1, 'h050, 1, 1, 'h051, 0);
        idle_steps(1);
        chk("resume_entry0", int'(o_pht_wr_entry), 3);
        idle_steps(1);
        chk("resume_entry1", int'(o_pht_wr_entry), 1);
        idle_steps(3);
        chk("final_q_empty", exp_q.size(), 0);
        chk("final_idle", int'(o_idle), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pht_update_module.md
# pht_update_module

Write-side companion of the 2048-entry pattern history table in the issue queue. It accepts up to two resolved-branch outcomes per cycle from commit, buffers them in order, and performs a saturating-counter read-modify-write on the PHT through one PHT read port and the single PHT write port. Back-to-back updates to the same index are forwarded internally, so no update is lost.

## Interface
Parameters:
- IDX_WIDTH, 11, PHT index width (2^IDX_WIDTH entries)
- CTR_WIDTH, 2, counter width
- FIFO_DEPTH, 8, update-buffer entries (power of two, ≥4)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous and active-high
- i_upd_vld_0 / i_upd_vld_1  input  1 each  update valid, slot 0 / slot 1
- i_upd_idx_0 / i_upd_idx_1  input  IDX_WIDTH each  PHT index
- i_upd_taken_0 / i_upd_taken_1  input  1 each  resolved direction (1 = taken)
- o_upd_rdy  output  1  both slots may be accepted this cycle
- o_pht_ridx  output  IDX_WIDTH  PHT read index (combinational from buffer head)
- i_pht_rd_entry  input  CTR_WIDTH  PHT read data, same cycle
- o_pht_wren  output  1  PHT write enable
- o_pht_widx  output  IDX_WIDTH  PHT write index
- o_pht_wr_entry  output  CTR_WIDTH  new counter value
- o_idle  output  1  buffer empty and no write in flight

## Operation
- Slot i is accepted when i_upd_vld_i & o_upd_rdy.
- o_upd_rdy = (free entries ≥ 2). It depends only on occupancy and never on the current vld inputs.
- Push order: slot 0, then slot 1. If only slot 1 is valid, it alone is pushed.
- Stage 0 (combinational):
  - If the buffer is non-empty, pop the head and drive o_pht_ridx = head.idx.
  - old = forward_hit ? s1_ctr : i_pht_rd_entry, where forward_hit = s1_vld & (s1_idx == head.idx).
- Counter rule, with max = 2^CTR_WIDTH−1:
  - taken → min(old+1, max)
  - not taken → max(old−1, 0)
  - No wrap-around in either direction.
- Stage 1 (registered):
  - s1_vld = popped & (new != old); s1_idx and s1_ctr are captured.
  - o_pht_wren = s1_vld, o_pht_widx = s1_idx, o_pht_wr_entry = s1_ctr.
- Write suppression: a saturated no-change update produces no write. Forwarding then correctly falls back to the PHT, because the PHT already holds that value.
- One pop per cycle. Two pushes per cycle can therefore fill the buffer; backpressure comes only from o_upd_rdy.
- o_pht_ridx is a don't-care when the buffer is empty; drive the head pointer's stale entry, unqualified.

## Timing
- Acceptance in cycle N → entry readable at head in cycle N+1.
  - Slot 0 pops in N+1 and its o_pht_wren is asserted in N+2.
  - Slot 1 pops in N+2 and its o_pht_wren is asserted in N+3.
- PHT array update lands on the clock edge ending the wren cycle.
- Simultaneous push and pop: occupancy = occ + pushes − pop. The full and empty flags come from the pointer difference with one extra wrap bit.
- Wrap-around: read and write pointers wrap modulo FIFO_DEPTH.
- Reset values, applied asynchronously on rst:
  - Buffer empty; s1_vld = 0.
  - o_pht_wren = 0, o_pht_widx = 0, o_pht_wr_entry = 0.
  - o_upd_rdy = 1, o_idle = 1.
- Reset mid-operation: all pending and in-flight updates are discarded. No write is issued after rst deasserts until new updates arrive.

## Structure
- Shared package iq_pht_pkg holds PHT_IDX_WIDTH = 11 and PHT_CTR_WIDTH = 2. The PHT table and this block both use these.
- The package also holds the function pht_ctr_next(old, taken) implementing the saturating rule.
- Sub-module pht_upd_fifo: 2-push / 1-pop FIFO storing {idx, taken}. It outputs a count, the head entry and a not-empty flag.
- The top level holds the stage-0 logic, the forwarding compare and the stage-1 registers.

## Test plan
- Single update: idx 0x155 taken, PHT entry = 1 → o_pht_wren in cycle N+2 with widx = 0x155, wr_entry = 2; o_idle = 1 in N+3.
- Saturation: idx 0x7FF taken with entry = 3, then not-taken with entry = 0 on another index → no o_pht_wren for either.
- Forwarding: both slots idx 0x010 taken in one cycle, PHT = 0 → writes of 1 then 2 in consecutive cycles, even though the second read still sees 0 from the array model.
- Backpressure: push two updates every cycle → o_upd_rdy drops when 7 entries are occupied. No accepted update is lost; writes stay in FIFO order, one per cycle.
- Slot-1-only push: vld_0 = 0, vld_1 = 1, idx 0x3A0 not-taken, entry = 2 → single write of 1 to 0x3A0.
- Reset mid-stream: assert rst with 5 entries buffered → wren = 0 immediately and o_upd_rdy = 1; no writes after deassert.
